// File: rtl/riscv_fetch_ctrl_if.sv
// Fetch-controller bus bundle: redirect from execute, imem request/response
// channels and the instruction stream handed to decode.
interface riscv_fetch_ctrl_if #(
    parameter int unsigned WORD_LENGTH = 32
);
    logic                   redirect_valid;
    logic [WORD_LENGTH-1:0] redirect_target;
    logic                   imem_req_valid;
    logic                   imem_req_ready;
    logic [WORD_LENGTH-1:0] imem_req_addr;
    logic                   imem_rsp_valid;
    logic [WORD_LENGTH-1:0] imem_rsp_data;
    logic                   inst_valid;
    logic                   inst_ready;
    logic [WORD_LENGTH-1:0] inst_data;
    logic [WORD_LENGTH-1:0] inst_pc;

    // Fetch controller side
    modport master (
        input  redirect_valid, redirect_target, imem_req_ready,
               imem_rsp_valid, imem_rsp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
    );

    // Environment side: execute, imem and decode
    modport slave (
        output redirect_valid, redirect_target, imem_req_ready,
               imem_rsp_valid, imem_rsp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
    );
endinterface

// File: rtl/riscv_fetch_ctrl.sv
// Instruction-fetch sequencer. Owns the fetch PC, keeps at most one imem
// request outstanding, buffers returned words in a 2-entry FIFO for decode
// and squashes anything made stale by a redirect from execute.
module riscv_fetch_ctrl #(
    parameter int unsigned             WORD_LENGTH = 32,
    parameter int unsigned             PC_OFFSET   = 4,
    parameter logic [WORD_LENGTH-1:0]  RESET_PC    = '0
) (
    input  logic               clk,
    input  logic               x_reset,
    riscv_fetch_ctrl_if.master bus
);
    localparam int unsigned W = WORD_LENGTH;

    // REQ: may issue; WAIT: one response due; DRAIN: due response is stale
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   fetch_pc;
    logic [W-1:0]   req_pc;
    logic [W-1:0]   fifo_pc   [2];
    logic [W-1:0]   fifo_data [2];
    logic           rd_ptr, wr_ptr;
    logic [1:0]     count;
    logic           outstanding, space, accept, push, pop, redirect, rsp;
    logic [W-1:0]   target_aligned;

    assign redirect       = bus.redirect_valid;
    assign rsp            = bus.imem_rsp_valid;
    // Low two bits of the target are forced to zero (word-aligned fetch)
    assign target_aligned = bus.redirect_target & ~W'(3);
    assign outstanding    = (state != S_REQ);
    // count + outstanding < 2; the sum never exceeds 3 so 2 bits suffice
    assign space          = (count + {1'b0, outstanding}) < 2'd2;
    assign accept         = bus.imem_req_valid & bus.imem_req_ready;
    assign pop            = bus.inst_valid & bus.inst_ready;
    // A response landing in the redirect cycle belongs to the old path
    assign push           = (state == S_WAIT) & rsp & ~redirect;

    // Next-state selection and request/decode-facing outputs
    always_comb begin
        state_nxt          = state;
        // Valid is forced low while reset is held so nothing leaks out
        bus.imem_req_valid = x_reset & (state == S_REQ) & space;
        bus.imem_req_addr  = fetch_pc;
        bus.inst_valid     = (count != 2'd0);
        bus.inst_data      = fifo_data[rd_ptr];
        bus.inst_pc        = fifo_pc[rd_ptr];
        case (state)
            S_REQ:   if (accept) state_nxt = redirect ? S_DRAIN : S_WAIT;
            S_WAIT:  if (rsp) state_nxt = S_REQ;
                     else if (redirect) state_nxt = S_DRAIN;
            S_DRAIN: if (rsp) state_nxt = S_REQ;
            default: state_nxt = S_REQ;
        endcase
    end

    // State, PC and FIFO occupancy registers
    always_ff @(posedge clk or negedge x_reset) begin
        if (!x_reset) begin
            state    <= S_REQ;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            state <= state_nxt;
            if (accept) req_pc <= fetch_pc;
            if (redirect)    fetch_pc <= target_aligned;
            else if (accept) fetch_pc <= fetch_pc + W'(PC_OFFSET);
            // Flush drops everything; a pop in the flush cycle has already
            // been seen by decode, so it needs no special handling
            if (redirect) begin
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
                count  <= 2'd0;
            end else begin
                rd_ptr <= rd_ptr ^ pop;
                wr_ptr <= wr_ptr ^ push;
                count  <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    // FIFO storage; contents are qualified by count so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= req_pc;
            fifo_data[wr_ptr] <= bus.imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_riscv_fetch_ctrl.sv
// Self-checking bench for riscv_fetch_ctrl: an imem responder with a
// programmable latency, plus queues of expected request addresses and
// decoded instructions that are filled by each test and drained by a monitor.
module tb_riscv_fetch_ctrl;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } inst_t;

    logic clk = 1'b0;
    logic x_reset;

    riscv_fetch_ctrl_if #(.WORD_LENGTH(32)) b0();
    riscv_fetch_ctrl_if #(.WORD_LENGTH(32)) b1();

    riscv_fetch_ctrl #(.WORD_LENGTH(32), .PC_OFFSET(4), .RESET_PC(32'h0))
        u0 (.clk(clk), .x_reset(x_reset), .bus(b0));
    riscv_fetch_ctrl #(.WORD_LENGTH(32), .PC_OFFSET(4), .RESET_PC(32'hFFFF_FFF8))
        u1 (.clk(clk), .x_reset(x_reset), .bus(b1));

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          n_acc  = 0;
    int          rsp_lat = 1;
    int          rsp_cnt = 0;
    logic [31:0] rsp_addr = '0;
    logic [31:0] exp_addr[$];
    inst_t       exp_inst[$];

    function automatic logic [31:0] f_inst(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    // Monitor: samples just before the rising edge, scores accepts and pops
    always begin
        @(negedge clk); #4;
        if (x_reset === 1'b1) begin
            if (b0.imem_req_valid === 1'b1 && b0.imem_req_ready === 1'b1) begin
                n_acc++;
                rsp_cnt  = rsp_lat;
                rsp_addr = b0.imem_req_addr;
                if (exp_addr.size() > 0) begin
                    logic [31:0] ea;
                    ea = exp_addr.pop_front();
                    n_chk++;
                    if (b0.imem_req_addr !== ea) begin
                        n_fail++;
                        $display("FAIL req_addr: got %h expected %h", b0.imem_req_addr, ea);
                    end
                end
            end
            if (b0.inst_valid === 1'b1 && b0.inst_ready === 1'b1) begin
                n_chk++;
                if (exp_inst.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_inst: got pc %h data %h expected none", b0.inst_pc, b0.inst_data);
                end else begin
                    inst_t ei;
                    ei = exp_inst.pop_front();
                    if (b0.inst_pc !== ei.pc || b0.inst_data !== ei.data) begin
                        n_fail++;
                        $display("FAIL inst: got pc %h data %h expected pc %h data %h",
                                 b0.inst_pc, b0.inst_data, ei.pc, ei.data);
                    end
                end
            end
        end
    end

    // imem model: answers rsp_lat cycles after an accept, one cycle wide
    always begin
        @(posedge clk); #1;
        if (rsp_cnt == 1) begin
            b0.imem_rsp_valid = 1'b1;
            b0.imem_rsp_data  = f_inst(rsp_addr);
            rsp_cnt = 0;
        end else begin
            b0.imem_rsp_valid = 1'b0;
            if (rsp_cnt > 1) rsp_cnt--;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        x_reset = 1'b0;
        b0.imem_req_ready  = 1'b0;
        b0.inst_ready      = 1'b0;
        b0.redirect_valid  = 1'b0;
        b0.redirect_target = '0;
        exp_addr.delete();
        exp_inst.delete();
        rsp_cnt = 0;
        rsp_lat = 1;
        n_acc   = 0;
        repeat (2) @(negedge clk);
        x_reset = 1'b1;
    endtask

    task automatic wait_q(input bit inst_q, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge clk);
            ok = inst_q ? (exp_inst.size() == 0) : (exp_addr.size() == 0);
        end
    endtask

    task automatic test_reset();
        bit ok;
        @(negedge clk);
        n_chk++;
        if (b0.imem_req_valid !== 1'b0 || b0.inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valids: got req %b inst %b expected 0 0", b0.imem_req_valid, b0.inst_valid);
        end
        do_reset();
        #1;
        n_chk++;
        if (b0.imem_req_valid !== 1'b1 || b0.imem_req_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_first_req: got valid %b addr %h expected 1 00000000",
                     b0.imem_req_valid, b0.imem_req_addr);
        end
        ok = 1'b1;
    endtask

    task automatic test_sequential();
        bit ok;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            exp_addr.push_back(32'(i * 4));
            exp_inst.push_back('{pc: 32'(i * 4), data: f_inst(32'(i * 4))});
        end
        b0.imem_req_ready = 1'b1;
        b0.inst_ready     = 1'b1;
        wait_q(1'b0, 30, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL seq_addr_timeout: got %0d left expected 0", exp_addr.size()); end
        b0.imem_req_ready = 1'b0;
        wait_q(1'b1, 30, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL seq_inst_timeout: got %0d left expected 0", exp_inst.size()); end
        @(negedge clk);
        n_chk++;
        if (b0.inst_valid !== 1'b0 || b0.imem_req_valid !== 1'b1 || b0.imem_req_addr !== 32'hC) begin
            n_fail++;
            $display("FAIL seq_idle: got inst_valid %b req %b addr %h expected 0 1 0000000c",
                     b0.inst_valid, b0.imem_req_valid, b0.imem_req_addr);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        exp_addr.push_back(32'h0);
        exp_addr.push_back(32'h4);
        b0.imem_req_ready = 1'b1;
        repeat (8) @(negedge clk);
        n_chk++;
        if (b0.imem_req_valid !== 1'b0 || n_acc != 2) begin
            n_fail++;
            $display("FAIL bp_full_stall: got req %b accepts %0d expected 0 2", b0.imem_req_valid, n_acc);
        end
        n_chk++;
        if (b0.inst_valid !== 1'b1 || b0.inst_pc !== 32'h0 || b0.inst_data !== f_inst(32'h0)) begin
            n_fail++;
            $display("FAIL bp_head_hold: got v %b pc %h data %h expected 1 00000000 %h",
                     b0.inst_valid, b0.inst_pc, b0.inst_data, f_inst(32'h0));
        end
        exp_addr.push_back(32'h8);
        for (int i = 0; i < 3; i++)
            exp_inst.push_back('{pc: 32'(i * 4), data: f_inst(32'(i * 4))});
        b0.inst_ready = 1'b1;
        wait_q(1'b0, 30, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL bp_addr_timeout: got %0d left expected 0", exp_addr.size()); end
        b0.imem_req_ready = 1'b0;
        wait_q(1'b1, 30, ok);
        n_chk++;
        if (!ok || n_acc != 3) begin
            n_fail++;
            $display("FAIL bp_drain: got %0d left accepts %0d expected 0 3", exp_inst.size(), n_acc);
        end
    endtask

    task automatic test_redirect_wait();
        bit ok;
        do_reset();
        rsp_lat = 2;
        exp_addr.push_back(32'h0);
        exp_addr.push_back(32'h4);
        exp_addr.push_back(32'h8);
        exp_inst.push_back('{pc: 32'h0, data: f_inst(32'h0)});
        b0.imem_req_ready = 1'b1;
        b0.inst_ready     = 1'b1;
        wait_q(1'b1, 30, ok);
        b0.inst_ready = 1'b0;
        wait_q(1'b0, 30, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL redir_setup_timeout: got %0d left expected 0", exp_addr.size()); end
        b0.redirect_valid  = 1'b1;
        b0.redirect_target = 32'h103;
        exp_addr.push_back(32'h100);
        exp_inst.push_back('{pc: 32'h100, data: f_inst(32'h100)});
        @(negedge clk);
        b0.redirect_valid = 1'b0;
        n_chk++;
        if (b0.inst_valid !== 1'b0 || b0.imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_flush: got inst_valid %b req %b expected 0 0", b0.inst_valid, b0.imem_req_valid);
        end
        b0.inst_ready = 1'b1;
        wait_q(1'b0, 30, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL redir_addr_timeout: got %0d left expected 0", exp_addr.size()); end
        b0.imem_req_ready = 1'b0;
        wait_q(1'b1, 30, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL redir_inst_timeout: got %0d left expected 0", exp_inst.size()); end
    endtask

    task automatic test_redirect_rsp_pop();
        bit ok;
        do_reset();
        exp_addr.push_back(32'h0);
        exp_addr.push_back(32'h4);
        exp_inst.push_back('{pc: 32'h0, data: f_inst(32'h0)});
        b0.imem_req_ready = 1'b1;
        wait_q(1'b0, 30, ok);
        // Response for 0x4 is on the bus this cycle; redirect and pop with it
        b0.redirect_valid  = 1'b1;
        b0.redirect_target = 32'h200;
        b0.inst_ready      = 1'b1;
        exp_addr.push_back(32'h200);
        exp_inst.push_back('{pc: 32'h200, data: f_inst(32'h200)});
        @(negedge clk);
        b0.redirect_valid = 1'b0;
        n_chk++;
        if (b0.inst_valid !== 1'b0 || b0.imem_req_valid !== 1'b1 || b0.imem_req_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL rsp_pop_redir: got inst_valid %b req %b addr %h expected 0 1 00000200",
                     b0.inst_valid, b0.imem_req_valid, b0.imem_req_addr);
        end
        wait_q(1'b0, 30, ok);
        b0.imem_req_ready = 1'b0;
        wait_q(1'b1, 30, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL rsp_pop_timeout: got %0d left expected 0", exp_inst.size()); end
    endtask

    task automatic test_wrap();
        logic [31:0] ea;
        do_reset();
        ea = 32'hFFFF_FFF8;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_chk++;
            if (b1.imem_req_valid !== 1'b1 || b1.imem_req_addr !== ea) begin
                n_fail++;
                $display("FAIL wrap_addr: got valid %b addr %h expected 1 %h", b1.imem_req_valid, b1.imem_req_addr, ea);
            end
            b1.imem_req_ready = 1'b1;
            @(negedge clk);
            b1.imem_req_ready = 1'b0;
            b1.imem_rsp_valid = 1'b1;
            b1.imem_rsp_data  = f_inst(ea);
            @(negedge clk);
            b1.imem_rsp_valid = 1'b0;
            n_chk++;
            if (b1.inst_valid !== 1'b1 || b1.inst_pc !== ea || b1.inst_data !== f_inst(ea)) begin
                n_fail++;
                $display("FAIL wrap_inst: got v %b pc %h data %h expected 1 %h %h",
                         b1.inst_valid, b1.inst_pc, b1.inst_data, ea, f_inst(ea));
            end
            ea = ea + 32'd4;
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok;
        do_reset();
        exp_addr.push_back(32'h0);
        exp_addr.push_back(32'h4);
        b0.imem_req_ready = 1'b1;
        for (int i = 0; i < 20 && n_acc < 1; i++) @(negedge clk);
        rsp_lat = 3;
        wait_q(1'b0, 30, ok);
        n_chk++;
        if (!ok || b0.inst_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_setup: got inst_valid %b expected 1", b0.inst_valid);
        end
        #2 x_reset = 1'b0;
        #1;
        n_chk++;
        if (b0.inst_valid !== 1'b0 || b0.imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: got inst_valid %b req %b expected 0 0", b0.inst_valid, b0.imem_req_valid);
        end
        b0.imem_req_ready = 1'b0;
        @(negedge clk);
        x_reset = 1'b1;
        #1;
        n_chk++;
        if (b0.imem_req_valid !== 1'b1 || b0.imem_req_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid_req: got valid %b addr %h expected 1 00000000", b0.imem_req_valid, b0.imem_req_addr);
        end
        // Stale response for 0x4 arrives in this cycle and must be ignored
        @(negedge clk);
        rsp_lat = 1;
        exp_addr.push_back(32'h0);
        exp_inst.push_back('{pc: 32'h0, data: f_inst(32'h0)});
        b0.imem_req_ready = 1'b1;
        b0.inst_ready     = 1'b1;
        wait_q(1'b0, 30, ok);
        b0.imem_req_ready = 1'b0;
        wait_q(1'b1, 30, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL rst_mid_inst_timeout: got %0d left expected 0", exp_inst.size()); end
    endtask

    initial begin
        x_reset = 1'b0;
        b0.imem_req_ready  = 1'b0;
        b0.inst_ready      = 1'b0;
        b0.redirect_valid  = 1'b0;
        b0.redirect_target = '0;
        b1.imem_req_ready  = 1'b0;
        b1.imem_rsp_valid  = 1'b0;
        b1.imem_rsp_data   = '0;
        b1.inst_ready      = 1'b1;
        b1.redirect_valid  = 1'b0;
        b1.redirect_target = '0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rsp_pop();
        test_wrap();
        test_reset_mid_wait();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
